// File: rtl/scu_dsp_loader_pkg.sv
// scu_dsp_loader_pkg: shared states, SCU port addresses and control bits
// for the SCU DSP bootstrap loader.
package scu_dsp_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      PCSET,
      PFETCH,
      PWRITE,
      DASET,
      DFETCH,
      DWRITE,
      RUN,
      POLL,
      FIN,
      STOP
   } ld_state_t;

   localparam logic [1:0] A_CTRL  = 2'd0;
   localparam logic [1:0] A_PROG  = 2'd1;
   localparam logic [1:0] A_DADDR = 2'd2;
   localparam logic [1:0] A_DDATA = 2'd3;

   localparam int EX_BIT = 16;
   localparam int LE_BIT = 15;
   localparam int EF_BIT = 18;

   function automatic logic [31:0] ctrl_word(
      input logic       ex,
      input logic       le,
      input logic [7:0] pc
   );
      logic [31:0] w;
      w         = '0;
      w[EX_BIT] = ex;
      w[LE_BIT] = le;
      w[7:0]    = pc;
      return w;
   endfunction

endpackage

// File: rtl/scu_dsp_loader_fetch.sv
// scu_dsp_loader_fetch: source req/ack handshake and word capture.
// REQ and ADDR hold until ACK; a squash drops REQ so a late ACK is ignored.
module scu_dsp_loader_fetch
   import scu_dsp_loader_pkg::*;
#(
   parameter int SRC_AW = 20
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ce,
   input  logic              i_go,
   input  logic              i_squash,
   input  logic [SRC_AW-1:0] i_addr,
   input  logic              i_ack,
   input  logic [31:0]       i_data,
   output logic              o_req,
   output logic [SRC_AW-1:0] o_addr,
   output logic              o_valid,
   output logic [31:0]       o_word
);

   logic              r_req;
   logic [SRC_AW-1:0] r_addr;
   logic              r_valid;
   logic [31:0]       r_word;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_word  <= '0;
      end else if (i_ce) begin
         r_valid <= 1'b0;
         if (i_squash) begin
            r_req <= 1'b0;
         end else if (r_req && i_ack) begin
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_word  <= i_data;
         end else if (i_go && !r_req) begin
            r_req  <= 1'b1;
            r_addr <= i_addr;
         end
      end
   end

   assign o_req   = r_req;
   assign o_addr  = r_addr;
   assign o_valid = r_valid;
   assign o_word  = r_word;

endmodule

// File: rtl/scu_dsp_loader.sv
// scu_dsp_loader: bootstraps the SCU DSP (program, data RAM, run, poll EF).
// Optional poll watchdog: define SCU_DSP_LOADER_WATCHDOG_EN.
module scu_dsp_loader
   import scu_dsp_loader_pkg::*;
#(
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 65535,
   parameter int SRC_AW   = 20
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE_R,
   input  logic              START,
   input  logic              ABORT,
   input  logic [8:0]        PROG_LEN,
   input  logic [8:0]        DATA_LEN,
   input  logic [7:0]        DATA_ADDR,
   input  logic [7:0]        START_PC,
   input  logic [SRC_AW-1:0] SRC_BASE,
   output logic              SRC_REQ,
   output logic [SRC_AW-1:0] SRC_ADDR,
   input  logic              SRC_ACK,
   input  logic [31:0]       SRC_DATA,
   output logic [1:0]        SCU_A,
   output logic [31:0]       SCU_DI,
   input  logic [31:0]       SCU_DO,
   output logic [3:0]        SCU_WR,
   output logic              SCU_RD,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int PW = $clog2(TIMEOUT + 1);

   ld_state_t         r_state, w_nxt_state;
   logic              r_acc, w_nxt_acc;
   logic [1:0]        r_a, w_nxt_a;
   logic [31:0]       r_di, w_nxt_di;
   logic              r_wr, w_nxt_wr;
   logic              r_rd, w_nxt_rd;
   logic              r_busy, w_nxt_busy;
   logic              r_done, w_nxt_done;
   logic              r_err, w_nxt_err;
   logic [8:0]        r_i, w_nxt_i;
   logic [8:0]        r_j, w_nxt_j;
   logic [GW-1:0]     r_gap, w_nxt_gap;
   logic [PW-1:0]     r_polls, w_nxt_polls;

   logic [8:0]        r_prog_len;
   logic [8:0]        r_data_len;
   logic [7:0]        r_data_addr;
   logic [7:0]        r_start_pc;
   logic [SRC_AW-1:0] r_src_base;

   logic              w_latch;
   logic              w_go;
   logic              w_squash;
   logic              w_req;
   logic              w_valid;
   logic [31:0]       w_word;
   logic [9:0]        w_off;
   logic [SRC_AW-1:0] w_src_addr;
   logic              w_unused_do;

   // Data words follow the program words in the source image.
   assign w_off = (r_state == DFETCH)
                ? ({1'b0, r_prog_len} + {1'b0, r_j})
                : {1'b0, r_i};
   assign w_src_addr = r_src_base + SRC_AW'(w_off);
   assign w_unused_do = ^{SCU_DO[31:EF_BIT+1], SCU_DO[EF_BIT-1:0]};

   scu_dsp_loader_fetch #(
      .SRC_AW (SRC_AW)
   ) u_fetch (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_ce     (CE_R),
      .i_go     (w_go),
      .i_squash (w_squash),
      .i_addr   (w_src_addr),
      .i_ack    (SRC_ACK),
      .i_data   (SRC_DATA),
      .o_req    (w_req),
      .o_addr   (SRC_ADDR),
      .o_valid  (w_valid),
      .o_word   (w_word)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_acc   = r_acc;
      w_nxt_a     = r_a;
      w_nxt_di    = r_di;
      w_nxt_wr    = 1'b0;
      w_nxt_rd    = 1'b0;
      w_nxt_busy  = r_busy;
      w_nxt_done  = 1'b0;
      w_nxt_err   = r_err;
      w_nxt_i     = r_i;
      w_nxt_j     = r_j;
      w_nxt_gap   = r_gap;
      w_nxt_polls = r_polls;
      w_latch     = 1'b0;
      w_go        = 1'b0;
      w_squash    = 1'b0;
      // An in-flight strobe has already had its period; it just drops here.
      if (ABORT && r_state != IDLE && r_state != STOP) begin
         w_nxt_state = STOP;
         w_nxt_acc   = 1'b0;
         w_squash    = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (START) begin
                  w_latch     = 1'b1;
                  w_nxt_state = PCSET;
                  w_nxt_busy  = 1'b1;
                  w_nxt_err   = 1'b0;
                  w_nxt_acc   = 1'b0;
                  w_nxt_i     = '0;
                  w_nxt_j     = '0;
                  w_nxt_gap   = '0;
                  w_nxt_polls = '0;
               end
            end
            PCSET: begin
               if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_CTRL;
                  w_nxt_di  = ctrl_word(1'b0, 1'b1, 8'h00);
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_state = (r_prog_len == 9'd0) ? DASET : PFETCH;
               end
            end
            PFETCH: begin
               if (w_valid) w_nxt_state = PWRITE;
               else if (!w_req) w_go = 1'b1;
            end
            PWRITE: begin
               if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_PROG;
                  w_nxt_di  = w_word;
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_i     = r_i + 9'd1;
                  w_nxt_state = (w_nxt_i == r_prog_len) ? DASET : PFETCH;
               end
            end
            DASET: begin
               if (r_data_len == 9'd0) begin
                  w_nxt_state = RUN;
               end else if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_DADDR;
                  w_nxt_di  = {24'h0, r_data_addr};
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_j     = '0;
                  w_nxt_state = DFETCH;
               end
            end
            DFETCH: begin
               if (w_valid) w_nxt_state = DWRITE;
               else if (!w_req) w_go = 1'b1;
            end
            DWRITE: begin
               if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_DDATA;
                  w_nxt_di  = w_word;
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_j     = r_j + 9'd1;
                  w_nxt_state = (w_nxt_j == r_data_len) ? RUN : DFETCH;
               end
            end
            RUN: begin
               if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_CTRL;
                  w_nxt_di  = ctrl_word(1'b1, 1'b0, r_start_pc);
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_gap   = '0;
                  w_nxt_state = POLL;
               end
            end
            POLL: begin
               if (!r_acc) begin
                  if (r_gap == GW'(POLL_GAP - 1)) begin
                     w_nxt_rd  = 1'b1;
                     w_nxt_a   = A_CTRL;
                     w_nxt_acc = 1'b1;
                     w_nxt_gap = '0;
                  end else begin
                     w_nxt_gap = r_gap + GW'(1);
                  end
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_polls = r_polls + PW'(1);
                  if (SCU_DO[EF_BIT]) begin
                     w_nxt_state = FIN;
`ifdef SCU_DSP_LOADER_WATCHDOG_EN
                  end else if (w_nxt_polls == PW'(TIMEOUT)) begin
                     w_nxt_err   = 1'b1;
                     w_nxt_state = STOP;
`endif
                  end
               end
            end
            FIN: begin
               w_nxt_done  = 1'b1;
               w_nxt_busy  = 1'b0;
               w_nxt_state = IDLE;
            end
            STOP: begin
               if (!r_acc) begin
                  w_nxt_wr  = 1'b1;
                  w_nxt_a   = A_CTRL;
                  w_nxt_di  = '0;
                  w_nxt_acc = 1'b1;
               end else begin
                  w_nxt_acc   = 1'b0;
                  w_nxt_busy  = 1'b0;
                  w_nxt_state = IDLE;
               end
            end
            default: w_nxt_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_acc       <= 1'b0;
         r_a         <= '0;
         r_di        <= '0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_i         <= '0;
         r_j         <= '0;
         r_gap       <= '0;
         r_polls     <= '0;
         r_prog_len  <= '0;
         r_data_len  <= '0;
         r_data_addr <= '0;
         r_start_pc  <= '0;
         r_src_base  <= '0;
      end else if (CE_R) begin
         r_state <= w_nxt_state;
         r_acc   <= w_nxt_acc;
         r_a     <= w_nxt_a;
         r_di    <= w_nxt_di;
         r_wr    <= w_nxt_wr;
         r_rd    <= w_nxt_rd;
         r_busy  <= w_nxt_busy;
         r_done  <= w_nxt_done;
         r_err   <= w_nxt_err;
         r_i     <= w_nxt_i;
         r_j     <= w_nxt_j;
         r_gap   <= w_nxt_gap;
         r_polls <= w_nxt_polls;
         if (w_latch) begin
            r_prog_len  <= PROG_LEN;
            r_data_len  <= DATA_LEN;
            r_data_addr <= DATA_ADDR;
            r_start_pc  <= START_PC;
            r_src_base  <= SRC_BASE;
         end
      end
   end

   assign SRC_REQ = w_req;
   assign SCU_A   = r_a;
   assign SCU_DI  = r_di;
   assign SCU_WR  = {4{r_wr}};
   assign SCU_RD  = r_rd;
   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign ERR     = r_err;

endmodule

// File: doc/scu_dsp_loader.md
Name: scu_dsp_loader

Overview:
- Sequencer that drives the SCU DSP register port (A/DI/DO/WR/RD) to bootstrap the DSP.
- Fetches program words, then optional data-RAM words, from a word-addressed source memory over a req/ack handshake.
- Writes those words through the DSP ports, starts execution, then polls the end flag.
- Sits between the system bus master side and the SCU instance; while BUSY, it is the sole driver of the SCU port.

Parameters:
- POLL_GAP, 16: CE_R cycles between successive end-flag reads.
- TIMEOUT, 65535: number of polls before the watchdog fires (used only with the optional feature).
- SRC_AW, 20: source word-address width.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- CE_R  in  1  clock enable; all FSM/counter/strobe updates occur only on CLK edges with CE_R=1
- START  in  1  one-cycle request, accepted only in IDLE on a CE_R cycle
- ABORT  in  1  stop request, level-sampled on CE_R cycles
- PROG_LEN  in  9  program words, 0..256 (0 = skip program phase)
- DATA_LEN  in  9  data words, 0..256 (0 = skip data phase)
- DATA_ADDR  in  8  initial data-RAM pointer {bank[7:6], addr[5:0]}
- START_PC  in  8  execution start PC
- SRC_BASE  in  SRC_AW  source word address of first program word
- SRC_REQ  out  1  source read request, held until ack
- SRC_ADDR  out  SRC_AW  source word address
- SRC_ACK  in  1  source data valid; sampled on CE_R cycles
- SRC_DATA  in  32  source word
- SCU_A  out  2  DSP port select
- SCU_DI  out  32  write data to SCU
- SCU_DO  in  32  read data from SCU
- SCU_WR  out  4  byte write enables
- SCU_RD  out  1  read strobe
- BUSY  out  1  high from START acceptance to return to IDLE
- DONE  out  1  one-CE-period pulse; DSP reached end flag
- ERR  out  1  sticky; cleared by the next accepted START

Behaviour:
- Reset values: SRC_REQ=0, SRC_ADDR=0, SCU_A=0, SCU_DI=0, SCU_WR=0, SCU_RD=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- Port constants:
  - A=0 control. Write bit16 EX, bit15 LE, bits7:0 PC. Read bit18 EF.
  - A=1 program data. A=2 data-RAM address. A=3 data-RAM data.
- Port access: registered strobes with WR=4'hF or RD=1, held exactly one CE_R period, then deasserted for at least one CE_R period before the next access.
- Port read: SCU_DO is sampled on the CE_R cycle that ends the RD period.
- START latches all inputs and resets counters; loader index i=0.
- States and transitions:
  - IDLE: START -> PCSET.
  - PCSET: write A=0, DI=0x00008000 (LE=1, PC=0) -> PFETCH; if PROG_LEN=0 -> DASET.
  - PFETCH: SRC_REQ=1, SRC_ADDR=SRC_BASE+i; on SRC_ACK capture the word, drop REQ -> PWRITE.
  - PWRITE: write A=1 with the captured word; i++. If i==PROG_LEN -> DASET, else -> PFETCH.
  - DASET: if DATA_LEN=0 -> RUN; else write A=2, DI={24'h0,DATA_ADDR} -> DFETCH with j=0.
  - DFETCH: SRC_ADDR=SRC_BASE+PROG_LEN+j; same handshake as PFETCH -> DWRITE.
  - DWRITE: write A=3; j++. If j==DATA_LEN -> RUN, else -> DFETCH.
  - RUN: write A=0, DI={15'h0,1'b1,8'h0,START_PC} -> POLL.
  - POLL: wait POLL_GAP CE cycles, then read A=0. If EF=1 -> FIN, else repeat.
  - FIN: DONE=1 for one CE period, BUSY=0 -> IDLE.
  - STOP: write A=0, DI=0 (EX=0) -> IDLE, BUSY=0, no DONE.
- Arithmetic:
  - SRC_ADDR wraps modulo 2^SRC_AW.
  - Counters are 9 bits, so PROG_LEN=256 completes after 256 writes with no overflow.
  - Data-RAM auto-increment is done by the SCU, not by this block.
- ABORT:
  - In any non-IDLE state -> STOP, including during an outstanding SRC_REQ; REQ drops immediately and a late ACK is ignored.
  - An in-flight port access completes its CE period before STOP.
  - ABORT in IDLE is ignored.
- START while BUSY is ignored. START and ABORT together in IDLE: START wins, and ABORT is acted on in the next CE cycle.
- Reset mid-operation: all outputs return to reset values immediately (async); no STOP write is issued.

Optional Feature:
- Macro: SCU_DSP_LOADER_WATCHDOG_EN.
- With the macro: a poll counter is active. On TIMEOUT polls without EF, ERR=1 and the FSM -> STOP (no DONE).
- Without the macro: POLL waits indefinitely and ERR is never set.

Decomposition:
- SCU_PKG holds:
  - the state enum (IDLE, PCSET, PFETCH, PWRITE, DASET, DFETCH, DWRITE, RUN, POLL, FIN, STOP);
  - the port address constants (0..3);
  - the control bit positions (EX=16, LE=15, EF=18).
- One natural sub-module, scu_dsp_loader_fetch: the SRC req/ack handshake, address generation, word capture and abort squash.

Test Plan:
- PROG_LEN=2, DATA_LEN=0, SRC words 0xAAAA0001/0xAAAA0002, START_PC=0x05, EF set on the 3rd poll.
  - Expect port writes A0=0x00008000, A1=0xAAAA0001, A1=0xAAAA0002, A0=0x00010005.
  - Expect 3 reads of A0, then one DONE pulse and BUSY low.
- PROG_LEN=1, DATA_LEN=2, DATA_ADDR=0x40, SRC_BASE=0x100.
  - Expect SRC_ADDR sequence 0x100, 0x101, 0x102.
  - Expect A2 written with 0x00000040, followed by two A3 writes.
- PROG_LEN=0, DATA_LEN=0 -> PCSET write, then the RUN write only; no SRC_REQ ever asserted.
- SRC_ACK delayed 10 CE cycles -> SRC_REQ and SRC_ADDR are held stable and no port strobes occur during the wait.
- ABORT asserted while SRC_REQ=1 -> REQ drops, A0=0x00000000 is written, BUSY falls, no DONE.
- With SCU_DSP_LOADER_WATCHDOG_EN, TIMEOUT=4, EF never set -> 4 polls, then ERR=1 and a STOP write; the next START clears ERR.
